// File: rtl/accum_block_avg.sv
// Block averager: sums 2^LOG2N unsigned samples, then presents the truncated mean and
// the remainder under a valid/ready handshake until the consumer takes them.
module accum_block_avg #(
   parameter int unsigned NBIT  = 8,
   parameter int unsigned LOG2N = 2
) (
   input  logic             C,
   input  logic             CLR,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [NBIT-1:0]  D,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [NBIT-1:0]  Q,
   output logic [LOG2N-1:0] R,
   output logic [LOG2N-1:0] CNT
);

   localparam int unsigned SW = NBIT + LOG2N;
   localparam int unsigned N  = 1 << LOG2N;
   localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

   typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [SW-1:0]    sum, sum_nxt, total;
   logic [LOG2N-1:0] cnt_nxt;
   logic [NBIT-1:0]  q_nxt;
   logic [LOG2N-1:0] r_nxt;
   logic             out_valid_nxt;
   logic             accept;

   // Ready depends only on registered state so the downstream handshake never reaches upstream.
   assign IN_READY = (state == ACC) && !CLR;
   assign accept   = IN_VALID && (state == ACC);
   assign total    = sum + SW'(D);

   always_ff @(posedge C or posedge CLR) begin
      if (CLR) begin
         state     <= ACC;
         sum       <= '0;
         CNT       <= '0;
         Q         <= '0;
         R         <= '0;
         OUT_VALID <= 1'b0;
      end else begin
         state     <= state_nxt;
         sum       <= sum_nxt;
         CNT       <= cnt_nxt;
         Q         <= q_nxt;
         R         <= r_nxt;
         OUT_VALID <= out_valid_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sum_nxt       = sum;
      cnt_nxt       = CNT;
      q_nxt         = Q;
      r_nxt         = R;
      out_valid_nxt = OUT_VALID;
      case (state)
         ACC: begin
            if (accept) begin
               if (CNT == LAST) begin
                  // Mean and remainder are just the high and low slices of the full sum.
                  q_nxt         = total[SW-1:LOG2N];
                  r_nxt         = total[LOG2N-1:0];
                  out_valid_nxt = 1'b1;
                  sum_nxt       = '0;
                  cnt_nxt       = '0;
                  state_nxt     = HOLD;
               end else begin
                  sum_nxt = total;
                  cnt_nxt = CNT + LOG2N'(1);
               end
            end
         end
         HOLD: begin
            if (OUT_READY) begin
               out_valid_nxt = 1'b0;
               state_nxt     = ACC;
            end
         end
         default: state_nxt = ACC;
      endcase
   end

endmodule

// File: tb/tb_accum_block_avg.sv
// Directed bench for accum_block_avg (NBIT=8, LOG2N=2) with hand-computed expectations.
module tb_accum_block_avg;

   logic       C = 1'b0;
   logic       CLR;
   logic       IN_VALID;
   logic       IN_READY;
   logic [7:0] D;
   logic       OUT_VALID;
   logic       OUT_READY;
   logic [7:0] Q;
   logic [1:0] R;
   logic [1:0] CNT;

   int vectors = 0;
   int errs    = 0;

   accum_block_avg #(.NBIT(8), .LOG2N(2)) dut (
      .C(C), .CLR(CLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .D(D),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .Q(Q), .R(R), .CNT(CNT)
   );

   always #5 C = ~C;

   task automatic chk(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge C);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      IN_VALID = 1'b1;
      D        = d;
      tick();
      IN_VALID = 1'b0;
   endtask

   task automatic result(input string tag, input int q, input int r);
      chk({tag, "_ov"}, int'(OUT_VALID), 1);
      chk({tag, "_q"}, int'(Q), q);
      chk({tag, "_r"}, int'(R), r);
      chk({tag, "_cnt"}, int'(CNT), 0);
      chk({tag, "_ir"}, int'(IN_READY), 0);
   endtask

   initial begin
      CLR = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; D = '0;
      #3;
      chk("rst_ov", int'(OUT_VALID), 0);
      chk("rst_q", int'(Q), 0);
      chk("rst_r", int'(R), 0);
      chk("rst_cnt", int'(CNT), 0);
      chk("rst_ir", int'(IN_READY), 0);
      @(negedge C);
      CLR = 1'b0;
      #1 chk("rel_ir", int'(IN_READY), 1);

      // Back-to-back block with consumer already ready: 101/4 = 25 r 1.
      OUT_READY = 1'b1;
      send(8'd10);
      chk("b1_cnt1", int'(CNT), 1);
      send(8'd20); send(8'd30); send(8'd41);
      result("b1", 25, 1);
      tick();
      chk("b1_ov_drop", int'(OUT_VALID), 0);
      chk("b1_ir_back", int'(IN_READY), 1);
      chk("b1_cnt_back", int'(CNT), 0);

      // Full-scale block: 1020 must not wrap.
      send(8'd255); send(8'd255); send(8'd255); send(8'd255);
      result("max", 255, 0);
      tick();

      // Backpressure: 10/4 = 2 r 2, offered sample 7 must not be absorbed.
      OUT_READY = 1'b0;
      send(8'd1); send(8'd2); send(8'd3); send(8'd4);
      result("bp", 2, 2);
      IN_VALID = 1'b1; D = 8'd7;
      for (int i = 0; i < 5; i++) begin
         tick();
         result("bp_stall", 2, 2);
      end
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      chk("bp_ov_drop", int'(OUT_VALID), 0);
      chk("bp_cnt", int'(CNT), 0);
      for (int i = 0; i < 4; i++) tick();
      result("bp7", 7, 0);
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      tick();

      // Gapped input: 23/4 = 5 r 3.
      send(8'd3);
      chk("gap_cnt1", int'(CNT), 1);
      tick(); tick();
      chk("gap_cnt1_hold", int'(CNT), 1);
      send(8'd5);
      chk("gap_cnt2", int'(CNT), 2);
      tick();
      chk("gap_cnt2_hold", int'(CNT), 2);
      send(8'd6);
      chk("gap_cnt3", int'(CNT), 3);
      send(8'd9);
      result("gap", 5, 3);
      tick();

      // CLR mid-block discards the partial sum.
      send(8'd100); send(8'd100);
      chk("mid_cnt2", int'(CNT), 2);
      #2 CLR = 1'b1;
      #1;
      chk("mid_clr_cnt", int'(CNT), 0);
      chk("mid_clr_ir", int'(IN_READY), 0);
      chk("mid_clr_ov", int'(OUT_VALID), 0);
      IN_VALID = 1'b1; D = 8'd99;
      tick();
      IN_VALID = 1'b0;
      chk("mid_clr_edge_cnt", int'(CNT), 0);
      @(negedge C);
      CLR = 1'b0;
      send(8'd4); send(8'd4); send(8'd4); send(8'd5);
      result("mid_after", 4, 1);

      // CLR while a result is pending.
      OUT_READY = 1'b0;
      tick();
      chk("hold_pending_ov", int'(OUT_VALID), 1);
      #2 CLR = 1'b1;
      #1;
      chk("hold_clr_ov", int'(OUT_VALID), 0);
      chk("hold_clr_q", int'(Q), 0);
      chk("hold_clr_r", int'(R), 0);
      @(negedge C);
      CLR = 1'b0;
      #1 chk("hold_rel_ir", int'(IN_READY), 1);
      send(8'd50);
      chk("hold_rel_cnt", int'(CNT), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
